// File: rtl/regfile_pkg.sv
// Shared widths and constants for the RV32I integer register file and its
// busy scoreboard.
package regfile_pkg;

   localparam int RegLen     = 32;
   localparam int RegAddrLen = 5;
   localparam int RegNum     = 32;

   localparam logic [RegAddrLen-1:0] RegAddrZero = '0;
   localparam logic [RegLen-1:0]     ZERO_WORD   = '0;

   localparam logic True  = 1'b1;
   localparam logic False = 1'b0;

endpackage : regfile_pkg

// File: rtl/regfile_if.sv
// Decode/write-back side bundle of the register file: two read ports, the
// write-back port, issue tracking, flush and the hazard stall.
interface regfile_if
   import regfile_pkg::*;
#(
   parameter int REG_WIDTH  = RegLen,
   parameter int ADDR_WIDTH = RegAddrLen
);
   logic                  rdy;
   logic                  re1;
   logic [ADDR_WIDTH-1:0] raddr1;
   logic [REG_WIDTH-1:0]  rdata1;
   logic                  re2;
   logic [ADDR_WIDTH-1:0] raddr2;
   logic [REG_WIDTH-1:0]  rdata2;
   logic                  we;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [REG_WIDTH-1:0]  wdata;
   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_rd;
   logic                  flush;
   logic                  hazard;

   modport master (
      output rdy, re1, raddr1, re2, raddr2, we, waddr, wdata,
             issue_valid, issue_rd, flush,
      input  rdata1, rdata2, hazard
   );

   modport slave (
      input  rdy, re1, raddr1, re2, raddr2, we, waddr, wdata,
             issue_valid, issue_rd, flush,
      output rdata1, rdata2, hazard
   );

endinterface : regfile_if

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking between issue and write-back; raises a stall
// when a requested source is still pending and not being written this cycle.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int REG_NUM    = RegNum,
   parameter int ADDR_WIDTH = RegAddrLen
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_rdy,
   input  logic                  i_we,
   input  logic [ADDR_WIDTH-1:0] i_waddr,
   input  logic                  i_issue_valid,
   input  logic [ADDR_WIDTH-1:0] i_issue_rd,
   input  logic                  i_flush,
   input  logic                  i_re1,
   input  logic [ADDR_WIDTH-1:0] i_raddr1,
   input  logic                  i_re2,
   input  logic [ADDR_WIDTH-1:0] i_raddr2,
   output logic                  o_hazard
);

   logic [REG_NUM-1:0] r_busy;
   logic [REG_NUM-1:0] w_busy_next;
   logic               w_wb_en;
   logic               w_pend1;
   logic               w_pend2;

   // NOTE: start from the held value so every path assigns w_busy_next and no latch is inferred.
   always_comb begin
      w_busy_next = r_busy;
      if (i_we && i_waddr != '0)
         w_busy_next[i_waddr] = False;
      // Set after clear: a younger issue to the same rd must stay pending.
      if (i_issue_valid && i_issue_rd != '0)
         w_busy_next[i_issue_rd] = True;
      w_busy_next[0] = False;
   end

   // NOTE: non-blocking assignment so all flops sample pre-edge values together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_busy <= '0;
      else if (i_rdy)
         r_busy <= i_flush ? '0 : w_busy_next;
   end

   assign w_wb_en  = i_rdy && i_we;
   assign w_pend1  = i_re1 && (i_raddr1 != '0) && r_busy[i_raddr1]
                     && !(w_wb_en && i_waddr == i_raddr1);
   assign w_pend2  = i_re2 && (i_raddr2 != '0) && r_busy[i_raddr2]
                     && !(w_wb_en && i_waddr == i_raddr2);
   assign o_hazard = w_pend1 | w_pend2;

endmodule : regfile_scoreboard

// File: rtl/regfile.sv
// RV32I integer register file: x0 hardwired to zero, two combinational read
// ports with same-cycle write-back bypass, one write port, RAW scoreboard.
module regfile
   import regfile_pkg::*;
#(
   parameter int REG_NUM    = RegNum,
   parameter int REG_WIDTH  = RegLen,
   parameter int ADDR_WIDTH = RegAddrLen
) (
   input logic       clk,
   input logic       rst_n,
   regfile_if.slave  bus
);

   logic [REG_WIDTH-1:0] r_regs [REG_NUM];
   logic                 w_wb_en;
   logic [REG_WIDTH-1:0] w_rdata1;
   logic [REG_WIDTH-1:0] w_rdata2;

   assign w_wb_en = bus.rdy && bus.we;

   // NOTE: the array is reset because architectural state must read as zero after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < REG_NUM; i++)
            r_regs[i] <= '0;
      end else if (w_wb_en && bus.waddr != '0) begin
         r_regs[bus.waddr] <= bus.wdata;
      end
   end

   function automatic logic [REG_WIDTH-1:0] read_port(
      input logic                  re,
      input logic [ADDR_WIDTH-1:0] raddr,
      input logic [REG_WIDTH-1:0]  stored,
      input logic                  wb_en,
      input logic [ADDR_WIDTH-1:0] waddr,
      input logic [REG_WIDTH-1:0]  wdata
   );
      if (!re || raddr == '0)
         return '0;
      else if (wb_en && waddr == raddr)
         return wdata;
      else
         return stored;
   endfunction

   assign w_rdata1   = read_port(bus.re1, bus.raddr1, r_regs[bus.raddr1],
                                 w_wb_en, bus.waddr, bus.wdata);
   assign w_rdata2   = read_port(bus.re2, bus.raddr2, r_regs[bus.raddr2],
                                 w_wb_en, bus.waddr, bus.wdata);
   assign bus.rdata1 = w_rdata1;
   assign bus.rdata2 = w_rdata2;

   regfile_scoreboard #(
      .REG_NUM    (REG_NUM),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scoreboard (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_rdy         (bus.rdy),
      .i_we          (bus.we),
      .i_waddr       (bus.waddr),
      .i_issue_valid (bus.issue_valid),
      .i_issue_rd    (bus.issue_rd),
      .i_flush       (bus.flush),
      .i_re1         (bus.re1),
      .i_raddr1      (bus.raddr1),
      .i_re2         (bus.re2),
      .i_raddr2      (bus.raddr2),
      .o_hazard      (bus.hazard)
   );

endmodule : regfile

// File: tb/tb_regfile.sv
// Scoreboard bench for regfile: stimulus pushes model expectations into a
// queue, a negedge monitor pops and compares against the DUT outputs.
module tb_regfile;
   import regfile_pkg::*;

   typedef struct {
      logic        rst_n;
      logic        rdy;
      logic        re1;
      logic [4:0]  a1;
      logic        re2;
      logic [4:0]  a2;
      logic        we;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic        iv;
      logic [4:0]  ird;
      logic        fl;
   } stim_t;

   typedef struct {
      string       name;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        hz;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   regfile_if bus ();

   regfile dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: architectural contents and set of pending registers.
   logic [31:0] m_regs [32];
   bit          m_busy [32];
   exp_t        exp_q [$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic stim_t idle();
      stim_t s;
      s = '{rst_n: 1'b1, rdy: 1'b1, re1: 1'b0, a1: 5'd0, re2: 1'b0, a2: 5'd0,
            we: 1'b0, wa: 5'd0, wd: 32'd0, iv: 1'b0, ird: 5'd0, fl: 1'b0};
      return s;
   endfunction

   function automatic logic [31:0] m_read(input stim_t s, input logic re, input logic [4:0] a);
      if (!re || a == 5'd0) return 32'd0;
      if (s.rdy && s.we && s.wa == a) return s.wd;
      return m_regs[a];
   endfunction

   function automatic logic m_pend(input stim_t s, input logic re, input logic [4:0] a);
      return re && a != 5'd0 && m_busy[a] && !(s.rdy && s.we && s.wa == a);
   endfunction

   task automatic apply(input string name, input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n           = s.rst_n;
      bus.rdy         = s.rdy;
      bus.re1         = s.re1;
      bus.raddr1      = s.a1;
      bus.re2         = s.re2;
      bus.raddr2      = s.a2;
      bus.we          = s.we;
      bus.waddr       = s.wa;
      bus.wdata       = s.wd;
      bus.issue_valid = s.iv;
      bus.issue_rd    = s.ird;
      bus.flush       = s.fl;
      if (!s.rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
         end
      end
      e.name = name;
      e.d1   = m_read(s, s.re1, s.a1);
      e.d2   = m_read(s, s.re2, s.a2);
      e.hz   = m_pend(s, s.re1, s.a1) | m_pend(s, s.re2, s.a2);
      exp_q.push_back(e);
      // State change the coming rising edge will make.
      if (s.rst_n && s.rdy) begin
         if (s.we && s.wa != 5'd0) m_regs[s.wa] = s.wd;
         if (s.fl) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else begin
            if (s.we && s.wa != 5'd0) m_busy[s.wa] = 1'b0;
            if (s.iv && s.ird != 5'd0) m_busy[s.ird] = 1'b1;
         end
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.name, ".rdata1"}, bus.rdata1, e.d1);
            check({e.name, ".rdata2"}, bus.rdata2, e.d2);
            check({e.name, ".hazard"}, {31'd0, bus.hazard}, {31'd0, e.hz});
         end
      end
   end

   function automatic logic [4:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
      return 5'($urandom_range(0, 7));
   endfunction

   initial begin : stimulus
      stim_t s;
      for (int i = 0; i < 32; i++) begin
         m_regs[i] = 32'd0;
         m_busy[i] = 1'b0;
      end
      bus.rdy = 1'b0; bus.re1 = 1'b0; bus.raddr1 = '0; bus.re2 = 1'b0; bus.raddr2 = '0;
      bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0; bus.issue_valid = 1'b0;
      bus.issue_rd = '0; bus.flush = 1'b0;

      s = idle(); s.rst_n = 1'b0; s.re1 = 1'b1; s.a1 = 5'd5; s.re2 = 1'b1; s.a2 = 5'd1;
      apply("reset_state", s);

      s = idle(); s.we = 1'b1; s.wa = 5'd5; s.wd = 32'h1234_5678; s.re1 = 1'b1; s.a1 = 5'd5;
      apply("bypass_x5", s);
      s = idle(); s.re1 = 1'b1; s.a1 = 5'd5;
      apply("stored_x5", s);
      s = idle(); s.rst_n = 1'b0; s.re1 = 1'b1; s.a1 = 5'd5;
      apply("reset_midop", s);
      s = idle(); s.re1 = 1'b1; s.a1 = 5'd5;
      apply("after_reset", s);

      s = idle(); s.we = 1'b1; s.wa = 5'd0; s.wd = 32'hFFFF_FFFF; s.iv = 1'b1; s.ird = 5'd0;
      s.re1 = 1'b1; s.a1 = 5'd0;
      apply("x0_write", s);
      s = idle(); s.re1 = 1'b1; s.a1 = 5'd0; s.re2 = 1'b1; s.a2 = 5'd0;
      apply("x0_read", s);

      s = idle(); s.we = 1'b1; s.wa = 5'd7; s.wd = 32'hDEAD_BEEF; s.re2 = 1'b1; s.a2 = 5'd7;
      apply("bypass_x7", s);
      s = idle(); s.re2 = 1'b1; s.a2 = 5'd7;
      apply("stored_x7", s);

      s = idle(); s.iv = 1'b1; s.ird = 5'd3;
      apply("issue_x3", s);
      s = idle(); s.re1 = 1'b1; s.a1 = 5'd3;
      apply("raw_stall", s);
      s = idle(); s.we = 1'b1; s.wa = 5'd3; s.wd = 32'h42; s.re1 = 1'b1; s.a1 = 5'd3;
      apply("raw_resolve", s);

      s = idle(); s.we = 1'b1; s.wa = 5'd9; s.wd = 32'h99; s.iv = 1'b1; s.ird = 5'd9;
      apply("set_clear_x9", s);
      s = idle(); s.re1 = 1'b1; s.a1 = 5'd9; s.fl = 1'b1;
      apply("set_wins", s);
      s = idle(); s.re1 = 1'b1; s.a1 = 5'd9;
      apply("after_flush", s);

      s = idle(); s.we = 1'b1; s.wa = 5'd4; s.wd = 32'h11;
      apply("write_x4", s);
      s = idle(); s.rdy = 1'b0; s.we = 1'b1; s.wa = 5'd4; s.wd = 32'h55; s.iv = 1'b1;
      s.ird = 5'd4; s.re1 = 1'b1; s.a1 = 5'd4;
      apply("rdy_freeze", s);
      s = idle(); s.re1 = 1'b1; s.a1 = 5'd4;
      apply("after_freeze", s);

      s = idle(); s.we = 1'b1; s.wa = 5'd31; s.wd = 32'hA5A5_0F0F;
      apply("write_x31", s);
      s = idle(); s.re2 = 1'b1; s.a2 = 5'd31; s.re1 = 1'b0; s.a1 = 5'd31;
      apply("read_x31", s);

      for (int n = 0; n < 400; n++) begin
         s     = idle();
         s.rdy = ($urandom_range(0, 9) != 0);
         s.re1 = ($urandom_range(0, 4) != 0);
         s.a1  = rand_addr();
         s.re2 = ($urandom_range(0, 4) != 0);
         s.a2  = rand_addr();
         s.we  = ($urandom_range(0, 1) != 0);
         s.wa  = rand_addr();
         s.wd  = 32'($urandom());
         s.iv  = ($urandom_range(0, 4) < 2);
         s.ird = rand_addr();
         s.fl  = ($urandom_range(0, 19) == 0);
         apply("random", s);
      end

      s = idle();
      apply("idle_end", s);
      repeat (3) @(posedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_regfile
